// File: rtl/uart_tx_arb_pkg.sv
// uart_arb_pkg: shared FSM state type for the uart_tx_arb arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin picker (req, ptr -> one-hot gnt, binary idx, any)
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);
  logic [NUM_REQ-1:0] rot;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     sum;
  // rotate the doubled vector so ptr lands at bit 0, then take the lowest set bit
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? PTR_W'(i) : off;
    sum = {1'b0, off} + {1'b0, ptr};
    idx = sum >= (PTR_W+1)'(NUM_REQ) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : sum[PTR_W-1:0];
  end
  assign any = |req;
  assign gnt = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding requester packets byte-by-byte to one UART_tx
//   req/pkt_len/pkt_data in from requesters, grant/done back to them,
//   trmt/tx_data out to UART_tx, tx_done in from UART_tx (rising edge used)
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_BYTES = 4,
  parameter int LEN_W = $clog2(MAX_BYTES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LEN_W-1:0]     pkt_len,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0] pkt_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         trmt,
  output logic [7:0]                   tx_data,
  input  logic                         tx_done
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int PKT_W = MAX_BYTES * 8;
  arb_state_t         state;
  logic [PKT_W-1:0]   shreg;
  logic [PKT_W-1:0]   sel_data;
  logic [LEN_W-1:0]   rem;
  logic [LEN_W-1:0]   sel_len;
  logic [LEN_W-1:0]   clamp;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic               tx_done_q;
  logic               rise;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign sel_len  = pkt_len[pick_idx*LEN_W +: LEN_W];
  assign sel_data = pkt_data[pick_idx*PKT_W +: PKT_W];
  assign clamp    = sel_len > LEN_W'(MAX_BYTES) ? LEN_W'(MAX_BYTES) : sel_len;
  assign rise     = tx_done & ~tx_done_q;
  // current byte always sits in the low byte of the shift register
  assign tx_data  = shreg[7:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      trmt      <= 1'b0;
      shreg     <= '0;
      rem       <= '0;
      ptr       <= '0;
      gidx      <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      done      <= '0;
      trmt      <= 1'b0;
      case (state)
        IDLE: if (pick_any) begin
          grant <= pick_gnt;
          gidx  <= pick_idx;
          shreg <= sel_data;
          rem   <= clamp;
          state <= clamp == '0 ? DONE : SEND;
          trmt  <= clamp != '0;
          done  <= clamp == '0 ? pick_gnt : '0;
        end
        SEND: state <= WAIT;
        WAIT: if (rise) begin
          shreg <= shreg >> 8;
          rem   <= rem - 1'b1;
          state <= rem == LEN_W'(1) ? DONE : SEND;
          trmt  <= rem != LEN_W'(1);
          done  <= rem == LEN_W'(1) ? grant : '0;
        end
        DONE: begin
          grant <= '0;
          ptr   <= gidx == PTR_W'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and byte sequencer that shares one `UART_tx` transmitter among several requesters.
- Each requester presents a packet of 0..`MAX_BYTES` bytes. The arbiter grants one requester, latches its packet, and feeds the bytes to `UART_tx` one at a time through `trmt`/`tx_data`/`tx_done`.
- It signals completion back to the requester, then rotates priority.
- It sits between the command/telemetry producers and the single serial `TX` pin.

## Interface
- `NUM_REQ`, 3, number of requesters (2..8)
- `MAX_BYTES`, 4, maximum packet length in bytes (1..8)
- `LEN_W`, `$clog2(MAX_BYTES+1)`, width of each length field (derived)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  `NUM_REQ`  per-requester packet request, level
- `pkt_len`  in  `NUM_REQ*LEN_W`  requester i length at `[i*LEN_W +: LEN_W]`; values above `MAX_BYTES` are clamped to `MAX_BYTES`
- `pkt_data`  in  `NUM_REQ*MAX_BYTES*8`  requester i packet at `[i*MAX_BYTES*8 +: MAX_BYTES*8]`; byte 0 is the LSB byte and is sent first
- `grant`  out  `NUM_REQ`  one-hot, high from the latch edge until the end of DONE
- `done`  out  `NUM_REQ`  one-cycle pulse to the granted requester when its packet is complete
- `trmt`  out  1  one-cycle transmit strobe to `UART_tx`
- `tx_data`  out  8  byte to `UART_tx`
- `tx_done`  in  1  from `UART_tx`; only its rising edge is used

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE: `req` is sampled only in this state.
  - If any bit is set, pick the first set bit at or after `ptr`, searching cyclically upward.
  - At that edge: register `grant`; latch the selected `pkt_data` into a byte shift register; latch the clamped length into a remaining-byte counter.
  - Go to SEND, or go directly to DONE if the length is 0.
- SEND: `trmt`=1 and `tx_data`=current byte for exactly one cycle. Go to WAIT.
- WAIT: `trmt`=0 and `tx_data` held.
  - Wait for the rising edge of `tx_done`, detected as `tx_done & ~tx_done_q` (`tx_done_q` is registered every cycle).
  - On the edge: shift to the next byte and decrement the counter. Go to SEND if bytes remain, else DONE.
  - A `tx_done` already high on entry to WAIT is not an edge.
- DONE: `done[g]`=1 for one cycle, where g is the granted index.
  - Set `ptr` = (g+1) mod `NUM_REQ`.
  - Clear `grant` at the end of the cycle. Return to IDLE.
- Requester contract: drop `req` at the edge ending the `done` cycle.
  - A `req` still high in IDLE is treated as a new packet.
  - `pkt_data`/`pkt_len` may change at any time after the latch edge.
- No timeout. WAIT persists until `tx_done` rises or `rst`.

## Timing
- Reset values: `grant`=0, `done`=0, `trmt`=0, `tx_data`=0, `ptr`=0, `tx_done_q`=0, state IDLE.
- All outputs are registered.
- Request latency: `req` high in cycle n (IDLE), then `grant` and `trmt` high in cycle n+1.
- Inter-byte gap: `tx_done` edge detected in cycle k, then `trmt` for the next byte in cycle k+1.
- Completion: last edge in cycle k, then `done` in cycle k+1, then IDLE in cycle k+2.
- Zero-length packet: `req` in cycle n, then `grant` and `done` both high in cycle n+1, with no `trmt`.
- Minimum spacing between two packets: two cycles from the `done` cycle to the next `grant`.
- Reset mid-packet (any state): the next cycle is in reset values. The packet is abandoned, not resumed, and no `done` is issued.
- `rst` has priority over every transition.

## Structure
- Package `uart_arb_pkg`: state enum `arb_state_t` {IDLE, SEND, WAIT, DONE}.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[NUM_REQ]`, `ptr`.
  - Outputs: one-hot `gnt`, binary `idx`, `any`.
  - Implemented as a doubled-vector priority search.
- Top: FSM, byte shift register (`MAX_BYTES*8`), remaining counter (`LEN_W`), `tx_done` edge register, pointer register.

## Test plan
Bench: `uart_tx_arb` drives a real `UART_tx`, whose `TX` loops back into `UART_rcv`. Checks use `rx_data`/`rx_rdy`.
- Single byte: `req[0]`, len 1, data 0x35. Required: one `trmt`, rx 0x35, `done[0]` one pulse, `grant`=001 from n+1 through the `done` cycle.
- Multi-byte: `req[1]`, len 3, data 0x97F818. Required: rx 0x18, 0xF8, 0x97 in order, three `trmt` pulses, a single `done[1]`.
- Contention: `req`=111 after reset, each len 1 (0x11, 0x22, 0x33). Required: served 0,1,2. Then `req`=101 with `ptr`=1. Required: requester 2 first, then 0.
- Zero length: `req[2]`, len 0. Required: `done[2]` in cycle n+1, no `trmt`, `ptr` becomes 0.
- Latch check: change `pkt_data[0]` from 0xF8 to 0x00 one cycle after `grant`. Required: rx 0xF8.
- Reset in WAIT during a 4-byte packet: assert `rst` for 1 cycle. Required next cycle: `grant`=0, `trmt`=0, `done`=0, `ptr`=0. A fresh `req[0]` is then served normally.
